// File: rtl/mem_copy_dma.sv
// rtl/mem_copy_dma.sv - word-granular memory copy/fill engine driving the unified memory port
module mem_copy_dma #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  input  logic             fill,
  input  logic [31:0]      fill_value,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      adr,
  output logic [31:0]      writedata,
  output logic             memwrite,
  input  logic [31:0]      readdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  logic [1:0]       state;
  logic [31:0]      src_r;
  logic [31:0]      dst_r;
  logic [LEN_W-1:0] len_r;
  logic             fill_r;
  logic [31:0]      fill_value_r;
  logic [31:0]      data_r;
  logic             err_r;
  logic [LEN_W-1:0] idx;

  logic [LEN_W:0]   idx_next;
  logic             last;
  logic [31:0]      ofs;

  assign idx_next = {1'b0, idx} + (LEN_W + 1)'(1);
  assign last     = (idx_next == {1'b0, len_r});
  // Byte offset of the current word; wraps modulo 2^32 when added to a base.
  assign ofs      = {{(30 - LEN_W){1'b0}}, idx, 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      src_r        <= '0;
      dst_r        <= '0;
      len_r        <= '0;
      fill_r       <= 1'b0;
      fill_value_r <= '0;
      data_r       <= '0;
      err_r        <= 1'b0;
      idx          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_r        <= src;
            dst_r        <= dst;
            len_r        <= len;
            fill_r       <= fill;
            fill_value_r <= fill_value;
            idx          <= '0;
            if (((src[1:0] != 2'b00) && !fill) || (dst[1:0] != 2'b00)) begin
              err_r <= 1'b1;
              state <= FIN;
            end else if (len == '0) begin
              state <= FIN;
            end else if (fill) begin
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          data_r <= readdata;
          state  <= WR;
        end
        WR: begin
          idx <= idx_next[LEN_W-1:0];
          if (last)        state <= FIN;
          else if (fill_r) state <= WR;
          else             state <= RD;
        end
        default: begin
          err_r <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    adr       = '0;
    writedata = '0;
    case (state)
      RD: adr = src_r + ofs;
      WR: begin
        adr       = dst_r + ofs;
        writedata = fill_r ? fill_value_r : data_r;
      end
      default: ;
    endcase
  end

  assign memwrite = (state == WR);
  assign busy     = (state == RD) || (state == WR);
  assign done     = (state == FIN);
  assign err      = (state == FIN) && err_r;

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb/tb_mem_copy_dma.sv - directed self-checking bench for mem_copy_dma
module tb_mem_copy_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src = '0;
  logic [31:0] dst = '0;
  logic [15:0] len = '0;
  logic        fill = 1'b0;
  logic [31:0] fill_value = '0;
  logic        busy, done, err, memwrite;
  logic [31:0] adr, writedata, readdata;

  logic [31:0] mem [0:255];

  int errors = 0;
  int checks = 0;

  int busy_first, busy_last, busy_cnt, wr_cnt, done_cnt, done_cyc;
  logic err_done;
  logic [31:0] wr_adr [$];

  mem_copy_dma #(.LEN_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
    .fill(fill), .fill_value(fill_value), .busy(busy), .done(done), .err(err),
    .adr(adr), .writedata(writedata), .memwrite(memwrite), .readdata(readdata)
  );

  always #5 clk = ~clk;

  assign readdata = mem[adr[9:2]];
  always @(posedge clk) if (memwrite) mem[adr[9:2]] <= writedata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one command at cycle 0 and records activity over cycles 1..ncyc.
  task automatic run(input logic f, input logic [31:0] s, input logic [31:0] d,
                     input logic [15:0] l, input logic [31:0] fv,
                     input int ncyc, input int inj, input int rst_at);
    busy_first = -1; busy_last = -1; busy_cnt = 0; wr_cnt = 0;
    done_cnt = 0; done_cyc = -1; err_done = 1'b0;
    wr_adr.delete();
    @(negedge clk);
    fill = f; src = s; dst = d; len = l; fill_value = fv; start = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      start = (k == inj);
      src = $urandom; dst = $urandom; len = 16'($urandom); fill = 1'($urandom);
      fill_value = $urandom;
      if (k == rst_at + 1) reset = 1'b1;
      if (busy) begin
        if (busy_first < 0) busy_first = k;
        busy_last = k;
        busy_cnt++;
      end
      if (memwrite) begin
        wr_cnt++;
        wr_adr.push_back(adr);
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = k;
          err_done = err;
        end
      end
      if (k == rst_at) begin
        check("rst_pre_memwrite", 32'(memwrite), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_memwrite_drop", 32'(memwrite), 32'd0);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset held low with random inputs
    for (int c = 0; c < 3; c++) begin
      start = 1'($urandom); src = $urandom; dst = $urandom; len = 16'($urandom);
      fill = 1'($urandom); fill_value = $urandom;
      @(negedge clk);
      check("rst_outputs", {busy, done, err, memwrite}, 32'd0);
      check("rst_adr", adr, 32'd0);
      check("rst_wdata", writedata, 32'd0);
    end
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_idle", {busy, done, err, memwrite}, 32'd0);

    // Copy 4 words 0x10 -> 0x40
    for (int i = 0; i < 4; i++) mem[4 + i] = 32'hA0 + i;
    run(1'b0, 32'h10, 32'h40, 16'd4, 32'h0, 14, -1, -1);
    check("copy_busy_first", busy_first, 1);
    check("copy_busy_last", busy_last, 8);
    check("copy_busy_cnt", busy_cnt, 8);
    check("copy_done_cyc", done_cyc, 9);
    check("copy_done_cnt", done_cnt, 1);
    check("copy_err", 32'(err_done), 32'd0);
    check("copy_writes", wr_cnt, 4);
    for (int i = 0; i < 4; i++) check("copy_data", mem[16 + i], 32'hA0 + i);

    // Fill 3 words at 0x80
    run(1'b1, 32'h0, 32'h80, 16'd3, 32'hDEADBEEF, 8, -1, -1);
    check("fill_busy_first", busy_first, 1);
    check("fill_busy_last", busy_last, 3);
    check("fill_writes", wr_cnt, 3);
    check("fill_done_cyc", done_cyc, 4);
    check("fill_adr0", wr_adr[0], 32'h80);
    for (int i = 0; i < 3; i++) check("fill_data", mem[32 + i], 32'hDEADBEEF);

    // Misaligned destination is rejected
    run(1'b0, 32'h10, 32'h42, 16'd2, 32'h0, 5, -1, -1);
    check("rej_done_cyc", done_cyc, 1);
    check("rej_err", 32'(err_done), 32'd1);
    check("rej_writes", wr_cnt, 0);
    check("rej_busy", busy_cnt, 0);

    // Misaligned source is irrelevant for fill
    run(1'b1, 32'h3, 32'h90, 16'd1, 32'h12345678, 5, -1, -1);
    check("fillsrc_err", 32'(err_done), 32'd0);
    check("fillsrc_done_cyc", done_cyc, 2);
    check("fillsrc_data", mem[36], 32'h12345678);

    // Zero length
    run(1'b0, 32'h10, 32'h40, 16'd0, 32'h0, 5, -1, -1);
    check("len0_done_cyc", done_cyc, 1);
    check("len0_err", 32'(err_done), 32'd0);
    check("len0_busy", busy_cnt, 0);
    check("len0_writes", wr_cnt, 0);

    // Start pulsed while busy is ignored
    run(1'b0, 32'h10, 32'hA0, 16'd2, 32'h0, 14, 2, -1);
    check("inj_done_cnt", done_cnt, 1);
    check("inj_done_cyc", done_cyc, 5);
    check("inj_writes", wr_cnt, 2);

    // Overlapping forward copy smears word 0
    for (int i = 0; i < 4; i++) mem[i] = i + 1;
    run(1'b0, 32'h0, 32'h4, 16'd3, 32'h0, 10, -1, -1);
    for (int i = 1; i < 4; i++) check("overlap_data", mem[i], 32'd1);

    // Address wrap across 0xFFFFFFFC
    run(1'b1, 32'h0, 32'hFFFFFFFC, 16'd2, 32'h55AA55AA, 6, -1, -1);
    check("wrap_writes", wr_cnt, 2);
    check("wrap_adr0", wr_adr[0], 32'hFFFFFFFC);
    check("wrap_adr1", wr_adr[1], 32'h00000000);
    check("wrap_err", 32'(err_done), 32'd0);

    // Reset during the second write of a 4-word copy
    for (int i = 0; i < 4; i++) mem[16 + i] = '0;
    run(1'b0, 32'h10, 32'h40, 16'd4, 32'h0, 12, -1, 4);
    check("midrst_done_cnt", done_cnt, 0);
    check("midrst_word0", mem[16], 32'hA0);
    check("midrst_word1", mem[17], 32'h0);
    check("midrst_word2", mem[18], 32'h0);
    check("midrst_idle", {busy, memwrite}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
